// File: rtl/conv_deinterleaver_param.sv
// Parameterised convolutional (de)interleaver: N_BRANCH commutated delay lines of
// M_UNIT-visit granularity packed into one flat circular-buffer memory.
module conv_deinterleaver_param #(
  parameter int N_BRANCH = 12,
  parameter int M_UNIT   = 17,
  parameter int DW       = 8
) (
  input  logic                        clk_bit,
  input  logic                        rst_n,
  input  logic                        mode,
  input  logic                        flush,
  input  logic                        din_valid,
  input  logic [DW-1:0]               din,
  input  logic                        sync_in,
  output logic                        dout_valid,
  output logic [DW-1:0]               dout,
  output logic                        sync_out,
  output logic [$clog2(N_BRANCH)-1:0] branch_idx,
  output logic                        sync_err
);

  localparam int BW    = $clog2(N_BRANCH);
  localparam int DMAX  = (N_BRANCH - 1) * M_UNIT;
  localparam int CW    = $clog2(DMAX + 1);
  localparam int DEPTH = M_UNIT * N_BRANCH * (N_BRANCH - 1) / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] MU  = M_UNIT;
  localparam logic [31:0] NB1 = N_BRANCH - 1;

  typedef enum logic {
    MODE_DEINT = 1'b0,
    MODE_INT   = 1'b1
  } mode_e;

  logic [BW-1:0] b;
  mode_e         mode_q;
  logic [CW-1:0] ptr  [N_BRANCH];
  logic [CW-1:0] fill [N_BRANCH];
  logic [DW-1:0] mem  [DEPTH];

  logic          accept;
  logic          resync_clear;
  mode_e         mode_eff;
  logic [BW-1:0] bsel;
  logic [BW-1:0] b_next;
  logic [CW-1:0] d_cur;
  logic [CW-1:0] ptr_cur;
  logic [CW-1:0] fill_cur;
  logic [CW-1:0] ptr_nxt;
  logic [CW-1:0] fill_nxt;
  logic [31:0]   base_w;
  logic [AW-1:0] addr;
  logic [DW-1:0] rd;
  logic [DW-1:0] dout_nxt;

  assign branch_idx = b;

  always_comb begin
    accept       = din_valid & ~flush;
    bsel         = sync_in ? '0 : b;
    b_next       = (bsel == BW'(N_BRANCH - 1)) ? '0 : bsel + BW'(1);
    mode_eff     = (accept & sync_in) ? mode_e'(mode) : mode_q;
    resync_clear = accept & sync_in & (mode_eff != mode_q);
    // Branch regions are laid out back to back in ascending branch order, so the
    // base of branch b is M_UNIT times the sum of the delay multipliers below it.
    if (mode_eff == MODE_INT) begin
      d_cur  = CW'(32'(bsel) * MU);
      base_w = MU * ((32'(bsel) * (32'(bsel) - 32'd1)) >> 1);
    end else begin
      d_cur  = CW'((NB1 - 32'(bsel)) * MU);
      base_w = MU * (32'(bsel) * NB1 - ((32'(bsel) * (32'(bsel) - 32'd1)) >> 1));
    end
    // A mode change makes this word the first visit of a freshly cleared branch.
    ptr_cur  = resync_clear ? '0 : ptr[bsel];
    fill_cur = resync_clear ? '0 : fill[bsel];
    ptr_nxt  = ((ptr_cur + CW'(1)) >= d_cur) ? '0 : ptr_cur + CW'(1);
    fill_nxt = (fill_cur >= d_cur) ? d_cur : fill_cur + CW'(1);
    addr     = AW'(base_w + 32'(ptr_cur));
    rd       = mem[addr];
    if (d_cur == '0) begin
      dout_nxt = din;
    end else if (fill_cur >= d_cur) begin
      dout_nxt = rd;
    end else begin
      dout_nxt = '0;
    end
  end

  always_ff @(posedge clk_bit) begin
    if (accept && (d_cur != '0)) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      b          <= '0;
      mode_q     <= MODE_DEINT;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_out   <= 1'b0;
      sync_err   <= 1'b0;
      for (int unsigned i = 0; i < N_BRANCH; i++) begin
        ptr[i]  <= '0;
        fill[i] <= '0;
      end
    end else begin
      dout_valid <= accept;
      sync_out   <= accept & sync_in;
      sync_err   <= accept & sync_in & (b != '0);
      if (flush) begin
        b      <= '0;
        mode_q <= mode_e'(mode);
        for (int unsigned i = 0; i < N_BRANCH; i++) begin
          ptr[i]  <= '0;
          fill[i] <= '0;
        end
      end else if (accept) begin
        b      <= b_next;
        mode_q <= mode_eff;
        dout   <= dout_nxt;
        if (resync_clear) begin
          for (int unsigned i = 0; i < N_BRANCH; i++) begin
            ptr[i]  <= '0;
            fill[i] <= '0;
          end
        end
        ptr[bsel]  <= ptr_nxt;
        fill[bsel] <= fill_nxt;
      end
    end
  end

endmodule

// File: tb/tb_conv_deinterleaver_param.sv
// Bench for conv_deinterleaver_param: three parameterisations checked against a
// per-branch history model, plus an interleave->deinterleave chain.
module tb_conv_deinterleaver_param;

  logic       clk_bit = 1'b0;
  logic       rst_n   = 1'b1;
  logic       mode    = 1'b0;
  logic       flush   = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din     = '0;
  logic       sync_in = 1'b0;
  logic       chain_sync = 1'b0;

  logic       a_valid, a_sync, a_err;
  logic [7:0] a_dout;
  logic [3:0] a_bidx;
  logic       b_valid, b_sync, b_err;
  logic [7:0] b_dout;
  logic [0:0] b_bidx;
  logic       c_valid, c_sync, c_err;
  logic [7:0] c_dout;
  logic [3:0] c_bidx;
  logic       i_valid, i_sync, i_err;
  logic [7:0] i_dout;
  logic [3:0] i_bidx;
  logic       d_valid, d_sync, d_err;
  logic [7:0] d_dout;
  logic [3:0] d_bidx;

  int n_vec = 0;
  int n_bad = 0;
  int c_cnt = 0;

  always #5 clk_bit = ~clk_bit;

  conv_deinterleaver_param u_a (
    .clk_bit(clk_bit), .rst_n(rst_n), .mode(mode), .flush(flush),
    .din_valid(din_valid), .din(din), .sync_in(sync_in),
    .dout_valid(a_valid), .dout(a_dout), .sync_out(a_sync),
    .branch_idx(a_bidx), .sync_err(a_err));

  conv_deinterleaver_param #(.N_BRANCH(2), .M_UNIT(1), .DW(8)) u_b (
    .clk_bit(clk_bit), .rst_n(rst_n), .mode(mode), .flush(flush),
    .din_valid(din_valid), .din(din), .sync_in(sync_in),
    .dout_valid(b_valid), .dout(b_dout), .sync_out(b_sync),
    .branch_idx(b_bidx), .sync_err(b_err));

  conv_deinterleaver_param #(.N_BRANCH(16), .M_UNIT(64), .DW(8)) u_c (
    .clk_bit(clk_bit), .rst_n(rst_n), .mode(mode), .flush(flush),
    .din_valid(din_valid), .din(din), .sync_in(sync_in),
    .dout_valid(c_valid), .dout(c_dout), .sync_out(c_sync),
    .branch_idx(c_bidx), .sync_err(c_err));

  conv_deinterleaver_param u_i (
    .clk_bit(clk_bit), .rst_n(rst_n), .mode(1'b1), .flush(1'b0),
    .din_valid(din_valid), .din(din), .sync_in(chain_sync),
    .dout_valid(i_valid), .dout(i_dout), .sync_out(i_sync),
    .branch_idx(i_bidx), .sync_err(i_err));

  conv_deinterleaver_param u_d (
    .clk_bit(clk_bit), .rst_n(rst_n), .mode(1'b0), .flush(1'b0),
    .din_valid(i_valid), .din(i_dout), .sync_in(i_sync),
    .dout_valid(d_valid), .dout(d_dout), .sync_out(d_sync),
    .branch_idx(d_bidx), .sync_err(d_err));

  // Model: each branch keeps the full list of words seen since its last clear;
  // an output is the entry d_b positions back, or 0 if the list is still short.
  logic [7:0] m_hist [3][16][1024];
  int         m_cnt  [3][16];
  int         m_b    [3];
  logic       m_mode [3];
  logic [7:0] e_dout [3];
  logic       e_valid[3];
  logic       e_sync [3];
  logic       e_err  [3];
  int         e_bidx [3];

  logic [7:0] c_in [32768];
  int         c_w;
  logic       c_v1, c_v2;
  logic [7:0] c_d1, c_d2;

  task automatic model_reset(input int k);
    for (int j = 0; j < 16; j++) m_cnt[k][j] = 0;
    m_b[k] = 0; m_mode[k] = 1'b0; e_dout[k] = '0;
    e_valid[k] = 1'b0; e_sync[k] = 1'b0; e_err[k] = 1'b0; e_bidx[k] = 0;
  endtask

  task automatic model_step(input int k, input int n, input int m);
    int br, dly, c;
    e_valid[k] = din_valid && !flush;
    e_sync[k]  = din_valid && !flush && sync_in;
    e_err[k]   = din_valid && !flush && sync_in && (m_b[k] != 0);
    if (flush) begin
      for (int j = 0; j < 16; j++) m_cnt[k][j] = 0;
      m_b[k] = 0;
      m_mode[k] = mode;
    end else if (din_valid) begin
      br = sync_in ? 0 : m_b[k];
      if (sync_in && (mode != m_mode[k])) begin
        for (int j = 0; j < 16; j++) m_cnt[k][j] = 0;
      end
      if (sync_in) m_mode[k] = mode;
      dly = m_mode[k] ? br * m : (n - 1 - br) * m;
      c = m_cnt[k][br];
      if (dly == 0)      e_dout[k] = din;
      else if (c >= dly) e_dout[k] = m_hist[k][br][(c - dly) % 1024];
      else               e_dout[k] = '0;
      m_hist[k][br][c % 1024] = din;
      m_cnt[k][br] = c + 1;
      m_b[k] = (br + 1) % n;
    end
    e_bidx[k] = m_b[k];
  endtask

  always @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) model_reset(k);
      c_w = 0; c_v1 = 1'b0; c_v2 = 1'b0; c_d1 = '0; c_d2 = '0;
    end else begin
      model_step(0, 12, 17);
      model_step(1, 2, 1);
      model_step(2, 16, 64);
      c_v2 = c_v1; c_d2 = c_d1;
      c_v1 = din_valid;
      if (din_valid) begin
        c_in[c_w] = din;
        c_d1 = (c_w >= 2244) ? c_in[c_w - 2244] : 8'h00;
        c_w++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_bit) begin
    check("a_dout", a_dout, e_dout[0]);   check("a_valid", a_valid, e_valid[0]);
    check("a_sync", a_sync, e_sync[0]);   check("a_err", a_err, e_err[0]);
    check("a_bidx", a_bidx, e_bidx[0]);
    check("b_dout", b_dout, e_dout[1]);   check("b_valid", b_valid, e_valid[1]);
    check("b_sync", b_sync, e_sync[1]);   check("b_err", b_err, e_err[1]);
    check("b_bidx", b_bidx, e_bidx[1]);
    check("c_dout", c_dout, e_dout[2]);   check("c_valid", c_valid, e_valid[2]);
    check("c_sync", c_sync, e_sync[2]);   check("c_err", c_err, e_err[2]);
    check("c_bidx", c_bidx, e_bidx[2]);
    check("chain_valid", d_valid, c_v2);
    if (c_v2) check("chain_dout", d_dout, c_d2);
    check("chain_i_err", i_err, 1'b0);
    check("chain_d_err", d_err, 1'b0);
  end

  task automatic step(input logic v, input logic [7:0] d, input logic s, input logic fl);
    din_valid = v; din = d; sync_in = s; flush = fl;
    chain_sync = v && (c_cnt % 204 == 0);
    if (v) c_cnt++;
    @(posedge clk_bit);
    #1;
  endtask

  task automatic word(input logic md);
    mode = md;
    step(1'b1, 8'(c_cnt), (c_cnt % 204) == 0, 1'b0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk_bit);
    #1;
    check("rst_dout", a_dout, 0);   check("rst_valid", a_valid, 0);
    check("rst_bidx", a_bidx, 0);   check("rst_err", a_err, 0);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("release_no_valid", a_valid, 0);

    // Gapless stream, sync every 204 words.
    for (int w = 0; w < 2600; w++) begin
      word(1'b0);
      if (w == 11 || w == 23)          check("p1_br11_pass", a_dout, w);
      if (w % 12 == 0 && w < 2244)     check("p1_br0_zero", a_dout, 0);
      if (w == 2244)                   check("p1_br0_first", a_dout, 0);
      if (w == 2245)                   check("p1_br1_first", a_dout, 205);
      if (w == 2256)                   check("p1_br0_second", a_dout, 12);
      if (w == 4)                      check("p1_n2_delay", b_dout, 2);
    end

    // Random 1-3 cycle gaps with junk on din.
    for (int w = 0; w < 400; w++) begin
      word(1'b0);
      repeat ($urandom_range(1, 3)) step(1'b0, 8'($urandom), 1'b0, 1'b0);
      if (w == 0) check("gap_no_valid", a_valid, 0);
    end

    // Misaligned sync while branch_idx == 5.
    for (int t = 0; t < 20; t++) begin
      if (a_bidx == 4'd5) break;
      step(1'b1, 8'(c_cnt), 1'b0, 1'b0);
    end
    check("reach_bidx5", a_bidx, 5);
    step(1'b1, 8'(c_cnt), 1'b1, 1'b0);
    check("mis_sync_err", a_err, 1);
    check("mis_sync_bidx", a_bidx, 1);
    step(1'b1, 8'(c_cnt), 1'b0, 1'b0);
    check("mis_sync_pulse_end", a_err, 0);

    // Mode change without sync is ignored; at the sync word histories restart.
    mode = 1'b1;
    for (int w = 0; w < 30; w++) step(1'b1, 8'(c_cnt), 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check("mode_sync_br0", a_dout, 8'hA5);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check("mode_br1_zero", a_dout, 0);
    for (int w = 0; w < 600; w++) word(1'b1);
    for (int w = 0; w < 300; w++) word(1'b0);

    // Flush mid-packet discards the offered word.
    step(1'b1, 8'h77, 1'b0, 1'b1);
    check("flush_valid", a_valid, 0);
    check("flush_bidx", a_bidx, 0);
    check("flush_n16_bidx", c_bidx, 0);
    for (int w = 0; w < 200; w++) word(1'b0);

    // Reset mid-stream, then a long run to fill the 16x64 instance.
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_dout", a_dout, 0);
    check("midrst_bidx", a_bidx, 0);
    @(posedge clk_bit);
    #1;
    rst_n = 1'b1;
    c_cnt = 0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("midrst_release_valid", a_valid, 0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    check("midrst_first_bidx", a_bidx, 1);
    for (int w = 0; w < 17000; w++) word(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_deinterleaver_param.md
CONV_DEINTERLEAVER_PARAM -- requirements
Module: conv_deinterleaver_param

Interface
REQ-001 SHALL have parameter N_BRANCH, default 12, number of commutator branches (legal range 2..16).
REQ-002 SHALL have parameter M_UNIT, default 17, delay unit in branch visits (legal range 1..64).
REQ-003 SHALL have parameter DW, default 8, data word width.
REQ-004 clk_bit  input  1  sole clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  1  0 = deinterleave, 1 = interleave.
REQ-007 flush  input  1  synchronous clear of stored history.
REQ-008 din_valid  input  1  din is accepted this cycle.
REQ-009 din  input  DW  input word.
REQ-010 sync_in  input  1  qualified by din_valid; marks the first word of a packet.
REQ-011 dout_valid  output  1  dout holds a valid word.
REQ-012 dout  output  DW  output word.
REQ-013 sync_out  output  1  sync_in delayed with its word.
REQ-014 branch_idx  output  clog2(N_BRANCH)  branch that will take the next accepted word.
REQ-015 sync_err  output  1  one-cycle pulse on misaligned sync.

Function
REQ-016 No backpressure: every cycle with din_valid=1 SHALL accept din.
REQ-017 Commutator b SHALL advance 0..N_BRANCH-1 and wrap to 0, changing only on accepted words.
REQ-018 An accepted word with sync_in=1 SHALL be routed to branch 0, regardless of b; the next word goes to branch 1.
REQ-019 sync_err SHALL pulse one cycle after an accepted sync word if b was not 0 at acceptance (the sync resynchronises anyway).
REQ-020 Branch delay d_b SHALL be (N_BRANCH-1-b)*M_UNIT visits for mode_q=0 and b*M_UNIT visits for mode_q=1.
REQ-021 Output for a word accepted on branch b SHALL be the word accepted on branch b exactly d_b visits earlier; for d_b=0 it SHALL be din itself.
REQ-022 Latency: dout, dout_valid and sync_out SHALL be registered, appearing exactly 1 clk_bit cycle after acceptance; dout_valid=0 in cycles following din_valid=0, and dout holds its value.
REQ-023 Storage SHALL be one flat memory of M_UNIT*N_BRANCH*(N_BRANCH-1)/2 words (1122 at defaults) with a per-branch circular pointer; pointer of branch b wraps at d_b and advances only on visits to b.
REQ-024 Per-branch fill counter SHALL count visits since the last clear, saturating at d_b; while fill < d_b, dout SHALL be 0 for that branch, not memory content.
REQ-025 mode_q SHALL load from mode on any accepted sync word and on flush; mode changes at other times SHALL be ignored.
REQ-026 When mode_q changes value, all fill counters and pointers SHALL clear in the same cycle; the triggering word is treated as the first visit after clear.
REQ-027 flush=1 SHALL clear pointers, fill counters and b to 0, SHALL drive dout_valid=0 next cycle, and SHALL discard a word offered the same cycle.
REQ-028 Arithmetic SHALL be unsigned with explicit wrap; no data-path word is modified, only delayed.

Reset
REQ-029 On rst_n=0: dout=0, dout_valid=0, sync_out=0, sync_err=0, branch_idx=0, mode_q=0, all pointers and fill counters 0; memory contents need not be cleared.
REQ-030 Reset mid-stream SHALL abandon all history; the first accepted word after release goes to branch 0.
REQ-031 Release of rst_n SHALL not itself produce dout_valid.

Verification
REQ-032 Defaults, mode=0, continuous din = 0,1,2,... with sync every 204 words -> branch-11 words appear unchanged 1 cycle later; first 187 branch-0 outputs are 0, and the 188th equals word index 0.
REQ-033 Chain interleave instance (mode=1) into deinterleave instance (mode=0) -> output reproduces input with total delay 2244 accepted words + 2 cycles; no errors.
REQ-034 Sync asserted while branch_idx=5 -> sync_err pulse 1 cycle later, word goes to branch 0, branch_idx=1 afterwards.
REQ-035 din_valid gaps of 1-3 cycles random -> identical output sequence to gapless run; dout_valid mirrors din_valid delayed 1.
REQ-036 Toggle mode without sync, then with sync -> no effect until the sync word; at the sync word fill counters clear and zeros reappear per REQ-024.
REQ-037 Flush and reset mid-packet, plus parameter sweep N_BRANCH=2 and M_UNIT=1, and N_BRANCH=16 and M_UNIT=64 -> per-branch delays match REQ-020 and outputs are 0 until filled.
